systolic_scheduler: RTL and testbench

Sequencer for the 4x4 weight-stationary PE array. It loads a weight tile into the array's weight inputs, then accepts a stream of activation vectors and applies the row skew at the array's left edge. It collects the column partial sums from the bottom edge, deskews them and emits one aligned result vector per accepted input. It sits between the NPU's buffer/DMA logic and the PE matrix, and is the only driver of the matrix inputs.

---
 rtl/npu_pkg.sv | 20 ++
 rtl/skew_line.sv | 28 ++
 rtl/systolic_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_systolic_scheduler.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU systolic sequencing logic.
package npu_pkg;

    localparam int N      = 4;
    localparam int DATA_W = 16;
    // Accept edge to result: skew + array traversal + deskew + output register.
    localparam int LAT    = 2 * N + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    typedef logic signed [N-1:0][DATA_W-1:0]        vec_t;
    typedef logic signed [N-1:0][N-1:0][DATA_W-1:0] tile_t;

endpackage

// File: rtl/skew_line.sv
// Fixed-depth WIDTH-bit delay line; building block of the skew, deskew and tag banks.
module skew_line #(
    parameter int WIDTH = 16,
    parameter int D     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [D-1:0][WIDTH-1:0] stage_reg;

    // Shift one stage per clock; the oldest stage is the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg[0] <= din;
            for (int k = 1; k < D; k++) begin
                stage_reg[k] <= stage_reg[k-1];
            end
        end
    end

    assign dout = stage_reg[D-1];

endmodule

// File: rtl/systolic_scheduler.sv
// Sequencer for the weight-stationary PE array: loads the weight tile, skews
// activation vectors into the left edge, deskews bottom-edge sums into aligned results.
module systolic_scheduler
    import npu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = npu_pkg::N
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [7:0]                     cfg_len,
    input  logic                           w_valid,
    input  logic [N-1:0][WIDTH-1:0]        w_data,
    output logic                           w_ready,
    input  logic                           act_valid,
    input  logic [N-1:0][WIDTH-1:0]        act_data,
    output logic                           act_ready,
    output logic [N-1:0][WIDTH-1:0]        pe_left,
    output logic [N-1:0][WIDTH-1:0]        pe_up,
    output logic [N-1:0][N-1:0][WIDTH-1:0] pe_weights,
    input  logic [N-1:0][WIDTH-1:0]        pe_down,
    output logic                           res_valid,
    output logic [N-1:0][WIDTH-1:0]        res_data,
    output logic                           busy,
    output logic                           done
);

    localparam int ROW_W = $clog2(N);
    localparam int DRN_W = $clog2(LAT);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(LAT - 1);

    state_t              state_reg;
    state_t              state_next;
    logic [ROW_W-1:0]    row_reg;
    logic [7:0]          len_reg;
    logic [7:0]          acc_reg;
    logic [DRN_W-1:0]    drain_reg;

    logic                    issue;
    logic                    w_accept;
    logic                    tag_tap;
    logic [N-1:0][WIDTH-1:0] inject;
    logic [N-1:0][WIDTH-1:0] deskewed;

    assign issue    = act_valid && act_ready;
    assign w_accept = w_valid && w_ready;

    // The top edge of the array never carries an incoming partial sum.
    assign pe_up = '0;

    // Next-state selection for the job sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = LOAD_W;
            end
            LOAD_W: begin
                if (w_accept && (row_reg == ROW_LAST)) begin
                    state_next = (len_reg == 8'd0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (issue && (({1'b0, acc_reg} + 9'd1) == {1'b0, len_reg})) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_reg == DRAIN_LAST) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, job counters and handshake/status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            len_reg   <= '0;
            acc_reg   <= '0;
            drain_reg <= '0;
            w_ready   <= 1'b0;
            act_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            w_ready   <= (state_next == LOAD_W);
            act_ready <= (state_next == STREAM);
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        len_reg <= cfg_len;
                        row_reg <= '0;
                    end
                end
                LOAD_W: begin
                    acc_reg <= '0;
                    if (w_accept) row_reg <= row_reg + 1'b1;
                end
                STREAM: begin
                    drain_reg <= '0;
                    if (issue) acc_reg <= acc_reg + 8'd1;
                end
                DRAIN: begin
                    drain_reg <= drain_reg + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Weight bank: written row by row during loading, held until the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_weights <= '0;
        end else if (w_accept) begin
            pe_weights[row_reg] <= w_data;
        end
    end

    // Non-issue cycles feed zeros so bubbles and drain cycles add nothing to the sums.
    always_comb begin
        inject = '0;
        if (issue) inject = act_data;
    end

    // Row i enters the array i cycles after row 0.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        skew_line #(.WIDTH(WIDTH), .D(gi + 1)) u_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (inject[gi]),
            .dout (pe_left[gi])
        );
    end

    // Column j leaves the array j cycles after column 0; delay the early ones to match.
    for (genvar gi = 0; gi < N; gi++) begin : g_deskew
        if (gi < N - 1) begin : g_dly
            skew_line #(.WIDTH(WIDTH), .D(N - 1 - gi)) u_deskew (
                .clk  (clk),
                .rst  (rst),
                .din  (pe_down[gi]),
                .dout (deskewed[gi])
            );
        end else begin : g_pass
            assign deskewed[gi] = pe_down[gi];
        end
    end

    // Valid tag follows each issue; the output register below is the final stage.
    skew_line #(.WIDTH(1), .D(LAT - 1)) u_tag (
        .clk  (clk),
        .rst  (rst),
        .din  (issue),
        .dout (tag_tap)
    );

    // Aligned result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= tag_tap;
            res_data  <= deskewed;
        end
    end

endmodule

// File: tb/tb_systolic_scheduler.sv
// Bench for systolic_scheduler: behavioural PE array on the matrix ports, a
// matrix-multiply scoreboard with fixed latency, and directed jobs.
module tb_systolic_scheduler;

    localparam int N       = 4;
    localparam int W       = 16;
    localparam int LATENCY = 9;

    typedef logic [N-1:0][W-1:0]        vec_t;
    typedef logic [N-1:0][N-1:0][W-1:0] tile_t;
    typedef struct {
        int   due;
        vec_t data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cfg_len;
    logic       w_valid;
    vec_t       w_data;
    logic       w_ready;
    logic       act_valid;
    vec_t       act_data;
    logic       act_ready;
    vec_t       pe_left;
    vec_t       pe_up;
    tile_t      pe_weights;
    vec_t       pe_down;
    logic       res_valid;
    vec_t       res_data;
    logic       busy;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    int last_row_cyc = 0;

    tile_t cur_tile;
    exp_t  exp_q[$];
    vec_t  res_log[$];
    int    res_cyc[$];
    int    issue_cyc[$];

    systolic_scheduler #(.WIDTH(W), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_len    (cfg_len),
        .w_valid    (w_valid),
        .w_data     (w_data),
        .w_ready    (w_ready),
        .act_valid  (act_valid),
        .act_data   (act_data),
        .act_ready  (act_ready),
        .pe_left    (pe_left),
        .pe_up      (pe_up),
        .pe_weights (pe_weights),
        .pe_down    (pe_down),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural PE matrix: each PE registers its right-going activation and
    // its down-going partial sum (up + left * weight) once per clock.
    logic [W-1:0] pe_r [N][N];
    logic [W-1:0] pe_d [N][N];

    initial begin
        logic [W-1:0] lin;
        logic [W-1:0] uin;
        int           prod;
        forever begin
            @(posedge clk or negedge rst);
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (!rst) begin
                        pe_r[i][j] <= '0;
                        pe_d[i][j] <= '0;
                    end else begin
                        if (j == 0) lin = pe_left[i];
                        else        lin = pe_r[i][j-1];
                        if (i == 0) uin = pe_up[j];
                        else        uin = pe_d[i-1][j];
                        prod = int'($signed(lin)) * int'($signed(pe_weights[i][j]));
                        pe_r[i][j] <= lin;
                        pe_d[i][j] <= uin + W'(prod);
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_down
        assign pe_down[gi] = pe_d[N-1][gi];
    end

    function automatic vec_t mk(input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v[0] = W'(e0);
        v[1] = W'(e1);
        v[2] = W'(e2);
        v[3] = W'(e3);
        return v;
    endfunction

    // Expected result: plain matrix product act x tile, wrapped to W bits.
    function automatic vec_t model(input vec_t a, input tile_t t);
        vec_t r;
        for (int j = 0; j < N; j++) begin
            int s = 0;
            for (int i = 0; i < N; i++) begin
                s += int'($signed(a[i])) * int'($signed(t[i][j]));
            end
            r[j] = W'(s);
        end
        return r;
    endfunction

    function automatic tile_t tile_ident();
        tile_t t;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                t[i][j] = (i == j) ? W'(1) : W'(0);
        return t;
    endfunction

    function automatic tile_t tile_const(input int c);
        tile_t t;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                t[i][j] = W'(c);
        return t;
    endfunction

    function automatic tile_t tile_seq();
        tile_t t;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                t[i][j] = W'(4 * i + j + 1);
        return t;
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_w_ready"},    256'(w_ready),    256'(0));
        check({tag, "_act_ready"},  256'(act_ready),  256'(0));
        check({tag, "_res_valid"},  256'(res_valid),  256'(0));
        check({tag, "_res_data"},   256'(res_data),   256'(0));
        check({tag, "_pe_left"},    256'(pe_left),    256'(0));
        check({tag, "_pe_up"},      256'(pe_up),      256'(0));
        check({tag, "_pe_weights"}, 256'(pe_weights), 256'(0));
        check({tag, "_busy"},       256'(busy),       256'(0));
        check({tag, "_done"},       256'(done),       256'(0));
    endtask

    // Scoreboard: every cycle res_valid must equal "an issue is exactly LATENCY cycles old".
    initial begin
        bit exp_valid;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
            end else begin
                exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                vectors++;
                if (res_valid !== exp_valid) begin
                    miscompares++;
                    $display("FAIL res_valid cyc=%0d: got %b, want %b", cyc, res_valid, exp_valid);
                end
                if (exp_valid) begin
                    vectors++;
                    if (res_data !== exp_q[0].data) begin
                        miscompares++;
                        $display("FAIL res_data cyc=%0d: got %h, want %h", cyc, res_data, exp_q[0].data);
                    end
                    $display("result cyc=%0d data=%h", cyc, res_data);
                    res_log.push_back(res_data);
                    res_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                end
                if (act_valid && act_ready) begin
                    exp_t e;
                    e.due  = cyc + LATENCY;
                    e.data = model(act_data, cur_tile);
                    exp_q.push_back(e);
                    issue_cyc.push_back(cyc);
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic load(input tile_t t, input bit noise);
        for (int r = 0; r < N; r++) begin
            w_valid = 1'b1;
            w_data  = t[r];
            if (noise) begin
                act_valid = 1'b1;
                act_data  = mk(7, 7, 7, 7);
            end
            @(negedge clk);
            check("load_w_ready", 256'(w_ready), 256'(1));
            if (noise) check("load_act_ready", 256'(act_ready), 256'(0));
            last_row_cyc = cyc;
            @(posedge clk); #1;
        end
        w_valid   = 1'b0;
        act_valid = 1'b0;
        act_data  = '0;
    endtask

    task automatic stream(input vec_t vecs[$], input int gap, input bit noise);
        int idx   = 0;
        int guard = 0;
        bit acc;
        while (idx < vecs.size() && guard < 300) begin
            act_valid = 1'b1;
            act_data  = vecs[idx];
            if (noise) begin
                w_valid = 1'b1;
                w_data  = mk(99, 99, 99, 99);
            end
            @(negedge clk);
            acc = act_ready && act_valid;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                idx++;
                act_valid = 1'b0;
                act_data  = '0;
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
            end
        end
        act_valid = 1'b0;
        act_data  = '0;
        w_valid   = 1'b0;
        check("stream_accepted", 256'(idx), 256'(vecs.size()));
    endtask

    task automatic wait_done(output int at);
        int k = 0;
        at = -1;
        while (k < 300) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
            k++;
        end
        vectors++;
        if (at < 0) begin
            miscompares++;
            $display("FAIL done_timeout: got no done, want a done pulse");
        end
        check("busy_in_done", 256'(busy), 256'(1));
        @(negedge clk);
        check("done_single_cycle", 256'(done), 256'(0));
        check("idle_after_done", 256'(busy), 256'(0));
        check("no_reload_after_done", 256'(w_ready), 256'(0));
        @(posedge clk); #1;
    endtask

    task automatic run_job(input tile_t t, input int len, input vec_t vecs[$],
                           input int gap, input bit noise, output int done_at);
        int done_before;
        res_log.delete();
        res_cyc.delete();
        issue_cyc.delete();
        done_before = done_cnt;
        cur_tile    = t;
        $display("job len=%0d gap=%0d noise=%0d", len, gap, noise);
        @(posedge clk); #1;
        start   = 1'b1;
        cfg_len = 8'(len);
        @(posedge clk); #1;
        start = 1'b0;
        load(t, noise);
        if (len > 0) stream(vecs, gap, noise);
        if (noise) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done(done_at);
        check("result_count", 256'(res_log.size()), 256'(len));
        check("done_count", 256'(done_cnt - done_before), 256'(1));
        check("weights_hold", 256'(pe_weights), 256'(t));
    endtask

    task automatic check_b_results(input string tag, input int gap);
        vec_t want [3];
        want[0] = mk(8, 8, 8, 8);
        want[1] = mk(4, 4, 4, 4);
        want[2] = mk(-2, -2, -2, -2);
        if (res_log.size() == 3 && issue_cyc.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                check({tag, "_literal"}, 256'(res_log[k]), 256'(want[k]));
            end
            for (int k = 1; k < 3; k++) begin
                check({tag, "_spacing"}, 256'(res_cyc[k] - res_cyc[k-1]),
                      256'(issue_cyc[k] - issue_cyc[k-1]));
                check({tag, "_gap"}, 256'(res_cyc[k] - res_cyc[k-1]), 256'(gap + 1));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t q[$];
        int   done_at;
        int   done_before;

        rst       = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        w_valid   = 1'b0;
        w_data    = '0;
        act_valid = 1'b0;
        act_data  = '0;
        cur_tile  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // Identity weights, single vector: result equals input, 9 cycles after accept.
        q.delete();
        q.push_back(mk(1, 2, 3, 4));
        run_job(tile_ident(), 1, q, 0, 1'b0, done_at);
        if (res_log.size() == 1 && issue_cyc.size() == 1) begin
            check("a_literal", 256'(res_log[0]), 256'(mk(1, 2, 3, 4)));
            check("a_latency", 256'(res_cyc[0] - issue_cyc[0]), 256'(9));
            check("a_done_after_result", 256'(done_at), 256'(res_cyc[0] + 1));
        end

        // All-2 weights, back-to-back.
        q.delete();
        q.push_back(mk(1, 1, 1, 1));
        q.push_back(mk(0, 1, 0, 1));
        q.push_back(mk(-1, 0, 0, 0));
        run_job(tile_const(2), 3, q, 0, 1'b0, done_at);
        check_b_results("b", 0);
        if (res_cyc.size() == 3) check("b_done_after_result", 256'(done_at), 256'(res_cyc[2] + 1));

        // Same job with two idle cycles between issues.
        run_job(tile_const(2), 3, q, 2, 1'b0, done_at);
        check_b_results("c", 2);

        // Zero-length job: weights load, done follows the last row directly.
        q.delete();
        run_job(tile_seq(), 0, q, 0, 1'b0, done_at);
        check("d_done_after_load", 256'(done_at), 256'(last_row_cyc + 1));
        repeat (5) @(posedge clk);
        #1;
        check("d_weights_still_held", 256'(pe_weights), 256'(tile_seq()));

        // Abort mid-stream with reset.
        res_log.delete();
        res_cyc.delete();
        issue_cyc.delete();
        done_before = done_cnt;
        cur_tile    = tile_ident();
        @(posedge clk); #1;
        start   = 1'b1;
        cfg_len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        load(tile_ident(), 1'b0);
        act_valid = 1'b1;
        act_data  = mk(5, 6, 7, 8);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b0;
        #1;
        check_zero("mid_reset");
        act_valid = 1'b0;
        act_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_done", 256'(done_cnt - done_before), 256'(0));
        check("abort_no_results", 256'(res_log.size()), 256'(0));
        check("abort_idle", 256'(busy), 256'(0));

        // Fresh job after the abort.
        q.delete();
        q.push_back(mk(1, 1, 1, 1));
        q.push_back(mk(0, 1, 0, 1));
        q.push_back(mk(-1, 0, 0, 0));
        run_job(tile_const(2), 3, q, 0, 1'b0, done_at);
        check_b_results("after_reset", 0);

        // Stray act_valid in load, stray w_valid in stream, start during drain; includes wrap.
        q.delete();
        q.push_back(mk(1, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 1));
        q.push_back(mk(32767, 0, 0, 0));
        run_job(tile_seq(), 3, q, 0, 1'b1, done_at);
        if (res_log.size() == 3) begin
            check("e_row0", 256'(res_log[0]), 256'(mk(1, 2, 3, 4)));
            check("e_row3", 256'(res_log[1]), 256'(mk(13, 14, 15, 16)));
            check("e_wrap", 256'(res_log[2]), 256'(mk(32767, -2, 32765, -4)));
        end
        repeat (3) @(posedge clk);
        #1;
        check("e_start_ignored", 256'(busy), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
